// File: rtl/memory_access_sequencer_pkg.sv
// Purpose: shared types and widths for the memory access sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package memory_access_sequencer_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_SRC1    = 3'd1,
        RD_SRC2    = 3'd2,
        RESULT     = 3'd3,
        WAIT_STORE = 3'd4,
        WR_DEST    = 3'd5
    } state_t;

endpackage

// File: rtl/memory_access_sequencer_if.sv
// Purpose: bundles the operand, result, store and memory-bus signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the bundle, result and store paths; req/ack on the bus.
interface memory_access_sequencer_if;
    import memory_access_sequencer_pkg::*;

    // Upstream address-calculated bundle
    logic              inValid;
    logic              inReady;
    logic              isMemSrc1In;
    logic              isMemSrc2In;
    logic              isMemDestIn;
    logic [DATA_W-1:0] addrSrc1In;
    logic [DATA_W-1:0] addrSrc2In;
    logic [DATA_W-1:0] addrDestIn;

    // Result towards execute
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] src1DataOut;
    logic [DATA_W-1:0] src2DataOut;
    logic              destPendingOut;

    // Store data from writeback
    logic              storeValidIn;
    logic [DATA_W-1:0] storeDataIn;
    logic              storeReadyOut;

    // Memory bus
    logic              memReqOut;
    logic              memWriteOut;
    logic [DATA_W-1:0] memAddrOut;
    logic [DATA_W-1:0] memWdataOut;
    logic              memAckIn;
    logic [DATA_W-1:0] memRdataIn;

    // Status
    logic [CNT_W-1:0]  stallCountOut;

    // Environment side: drives bundles, consumes results, answers the bus
    modport master (
        output inValid, isMemSrc1In, isMemSrc2In, isMemDestIn,
               addrSrc1In, addrSrc2In, addrDestIn,
               outReady, storeValidIn, storeDataIn, memAckIn, memRdataIn,
        input  inReady, outValid, src1DataOut, src2DataOut, destPendingOut,
               storeReadyOut, memReqOut, memWriteOut, memAddrOut, memWdataOut,
               stallCountOut
    );

    // Sequencer side
    modport slave (
        input  inValid, isMemSrc1In, isMemSrc2In, isMemDestIn,
               addrSrc1In, addrSrc2In, addrDestIn,
               outReady, storeValidIn, storeDataIn, memAckIn, memRdataIn,
        output inReady, outValid, src1DataOut, src2DataOut, destPendingOut,
               storeReadyOut, memReqOut, memWriteOut, memAddrOut, memWdataOut,
               stallCountOut
    );

endinterface

// File: rtl/memory_access_sequencer.sv
// Purpose: loads memory source operands, hands them to execute, then writes the memory destination.
// Latency: result 1 cycle after accept plus 1+wait cycles per source read; store write 1+wait cycles.
// Backpressure: accepts only in IDLE; result held until outReady; bus request held until ack.
module memory_access_sequencer
    import memory_access_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    memory_access_sequencer_if.slave bus
);

    state_t            state_q;
    logic              src2_flag_q;
    logic              dest_flag_q;
    logic [DATA_W-1:0] src2_addr_q;
    logic [DATA_W-1:0] dest_addr_q;
    logic [DATA_W-1:0] src1_data_q;
    logic [DATA_W-1:0] src2_data_q;
    logic              out_valid_q;
    logic              dest_pending_q;
    logic              store_ready_q;
    logic              mem_req_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    // Bus-wait counter: counts request cycles without ack, sticks at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_req_q && !bus.memAckIn && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register; cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Sequencer FSM with registered bus/result outputs; reset abandons any bus access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            src2_flag_q    <= 1'b0;
            dest_flag_q    <= 1'b0;
            src2_addr_q    <= '0;
            dest_addr_q    <= '0;
            src1_data_q    <= '0;
            src2_data_q    <= '0;
            out_valid_q    <= 1'b0;
            dest_pending_q <= 1'b0;
            store_ready_q  <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.inValid) begin
                        src2_flag_q    <= bus.isMemSrc2In;
                        dest_flag_q    <= bus.isMemDestIn;
                        src2_addr_q    <= bus.addrSrc2In;
                        dest_addr_q    <= bus.addrDestIn;
                        // Non-memory sources must read back as zero
                        src1_data_q    <= '0;
                        src2_data_q    <= '0;
                        dest_pending_q <= bus.isMemDestIn;
                        if (bus.isMemSrc1In) begin
                            state_q    <= RD_SRC1;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.addrSrc1In;
                        end else if (bus.isMemSrc2In) begin
                            state_q    <= RD_SRC2;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.addrSrc2In;
                        end else begin
                            state_q     <= RESULT;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RD_SRC1: begin
                    if (bus.memAckIn) begin
                        src1_data_q <= bus.memRdataIn;
                        if (src2_flag_q) begin
                            // Request stays up; only the address moves to src2
                            state_q    <= RD_SRC2;
                            mem_addr_q <= src2_addr_q;
                        end else begin
                            state_q     <= RESULT;
                            mem_req_q   <= 1'b0;
                            mem_addr_q  <= '0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RD_SRC2: begin
                    if (bus.memAckIn) begin
                        src2_data_q <= bus.memRdataIn;
                        state_q     <= RESULT;
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= '0;
                        out_valid_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.outReady) begin
                        out_valid_q <= 1'b0;
                        if (dest_flag_q) begin
                            state_q       <= WAIT_STORE;
                            store_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT_STORE: begin
                    if (bus.storeValidIn) begin
                        state_q       <= WR_DEST;
                        store_ready_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        mem_write_q   <= 1'b1;
                        mem_addr_q    <= dest_addr_q;
                        mem_wdata_q   <= bus.storeDataIn;
                    end
                end
                WR_DEST: begin
                    if (bus.memAckIn) begin
                        state_q        <= IDLE;
                        mem_req_q      <= 1'b0;
                        mem_write_q    <= 1'b0;
                        mem_addr_q     <= '0;
                        mem_wdata_q    <= '0;
                        dest_pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // inReady is forced low while reset is held so every output reads 0 during reset
    assign bus.inReady        = (state_q == IDLE) && !reset;
    assign bus.outValid       = out_valid_q;
    assign bus.src1DataOut    = src1_data_q;
    assign bus.src2DataOut    = src2_data_q;
    assign bus.destPendingOut = dest_pending_q;
    assign bus.storeReadyOut  = store_ready_q;
    assign bus.memReqOut      = mem_req_q;
    assign bus.memWriteOut    = mem_write_q;
    assign bus.memAddrOut     = mem_addr_q;
    assign bus.memWdataOut    = mem_wdata_q;
    assign bus.stallCountOut  = stall_cnt_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Purpose: directed self-checking bench for memory_access_sequencer.
// Latency: checks taken 1ns after each rising edge against hand-computed values.
// Backpressure: exercises outReady stalls, bus wait states and store handshakes.
module tb_memory_access_sequencer;

    logic clk;
    logic reset;
    int   cmp_cnt;
    int   err_cnt;

    memory_access_sequencer_if sif ();

    memory_access_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        sif.inValid = 0; sif.isMemSrc1In = 0; sif.isMemSrc2In = 0; sif.isMemDestIn = 0;
        sif.addrSrc1In = '0; sif.addrSrc2In = '0; sif.addrDestIn = '0;
        sif.outReady = 0; sif.storeValidIn = 0; sif.storeDataIn = '0;
        sif.memAckIn = 0; sif.memRdataIn = '0;
        #1;
        // Reset state
        chk("rst_inready",  64'(sif.inReady), 64'd0);
        chk("rst_memreq",   64'(sif.memReqOut), 64'd0);
        chk("rst_outvalid", 64'(sif.outValid), 64'd0);
        chk("rst_stall",    64'(sif.stallCountOut), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_release_inready", 64'(sif.inReady), 64'd1);

        // Scenario 1: no memory operands
        sif.inValid = 1; sif.addrSrc1In = 64'h111; sif.addrSrc2In = 64'h222; sif.addrDestIn = 64'h333;
        step();
        sif.inValid = 0;
        chk("s1_outvalid", 64'(sif.outValid), 64'd1);
        chk("s1_src1",     sif.src1DataOut, 64'd0);
        chk("s1_src2",     sif.src2DataOut, 64'd0);
        chk("s1_memreq",   64'(sif.memReqOut), 64'd0);
        chk("s1_inready",  64'(sif.inReady), 64'd0);
        chk("s1_destpend", 64'(sif.destPendingOut), 64'd0);
        sif.outReady = 1;
        step();
        sif.outReady = 0;
        chk("s1_done_outvalid", 64'(sif.outValid), 64'd0);
        chk("s1_done_inready",  64'(sif.inReady), 64'd1);
        chk("s1_done_memreq",   64'(sif.memReqOut), 64'd0);

        // Scenario 2: two reads, each acked on its third request cycle
        sif.inValid = 1; sif.isMemSrc1In = 1; sif.isMemSrc2In = 1;
        sif.addrSrc1In = 64'h1000; sif.addrSrc2In = 64'h2000;
        step();
        sif.inValid = 0; sif.isMemSrc1In = 0; sif.isMemSrc2In = 0;
        chk("s2_rd1_req",   64'(sif.memReqOut), 64'd1);
        chk("s2_rd1_write", 64'(sif.memWriteOut), 64'd0);
        chk("s2_rd1_addr",  sif.memAddrOut, 64'h1000);
        step();
        chk("s2_rd1_addr_hold", sif.memAddrOut, 64'h1000);
        chk("s2_rd1_stall1",    64'(sif.stallCountOut), 64'd1);
        step();
        chk("s2_rd1_stall2",    64'(sif.stallCountOut), 64'd2);
        chk("s2_rd1_outvalid",  64'(sif.outValid), 64'd0);
        sif.memAckIn = 1; sif.memRdataIn = 64'hAA;
        step();
        sif.memAckIn = 0; sif.memRdataIn = '0;
        chk("s2_rd2_req",  64'(sif.memReqOut), 64'd1);
        chk("s2_rd2_addr", sif.memAddrOut, 64'h2000);
        chk("s2_rd2_src1", sif.src1DataOut, 64'hAA);
        step();
        step();
        chk("s2_rd2_stall4", 64'(sif.stallCountOut), 64'd4);
        sif.memAckIn = 1; sif.memRdataIn = 64'hBB;
        step();
        sif.memAckIn = 0; sif.memRdataIn = '0;
        chk("s2_outvalid", 64'(sif.outValid), 64'd1);
        chk("s2_src1",     sif.src1DataOut, 64'hAA);
        chk("s2_src2",     sif.src2DataOut, 64'hBB);
        chk("s2_memreq",   64'(sif.memReqOut), 64'd0);
        chk("s2_memaddr",  sif.memAddrOut, 64'd0);
        chk("s2_stall",    64'(sif.stallCountOut), 64'd4);
        sif.outReady = 1;
        step();
        sif.outReady = 0;
        chk("s2_done_inready", 64'(sif.inReady), 64'd1);

        // Scenario 3: destination store with result backpressure
        sif.inValid = 1; sif.isMemDestIn = 1; sif.addrDestIn = 64'h3000;
        step();
        sif.inValid = 0; sif.isMemDestIn = 0;
        chk("s3_destpend", 64'(sif.destPendingOut), 64'd1);
        chk("s3_src1_cleared", sif.src1DataOut, 64'd0);
        chk("s3_src2_cleared", sif.src2DataOut, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("s3_outvalid_held", 64'(sif.outValid), 64'd1);
            step();
        end
        chk("s3_outvalid_4th", 64'(sif.outValid), 64'd1);
        sif.outReady = 1;
        step();
        sif.outReady = 0;
        chk("s3_ws_outvalid",   64'(sif.outValid), 64'd0);
        chk("s3_ws_storeready", 64'(sif.storeReadyOut), 64'd1);
        chk("s3_ws_destpend",   64'(sif.destPendingOut), 64'd1);
        chk("s3_ws_memreq",     64'(sif.memReqOut), 64'd0);
        sif.storeValidIn = 1; sif.storeDataIn = 64'h55;
        step();
        sif.storeValidIn = 0; sif.storeDataIn = '0;
        chk("s3_wr_req",        64'(sif.memReqOut), 64'd1);
        chk("s3_wr_write",      64'(sif.memWriteOut), 64'd1);
        chk("s3_wr_addr",       sif.memAddrOut, 64'h3000);
        chk("s3_wr_data",       sif.memWdataOut, 64'h55);
        chk("s3_wr_storeready", 64'(sif.storeReadyOut), 64'd0);
        chk("s3_wr_destpend",   64'(sif.destPendingOut), 64'd1);
        sif.memAckIn = 1;
        step();
        sif.memAckIn = 0;
        chk("s3_done_destpend", 64'(sif.destPendingOut), 64'd0);
        chk("s3_done_memreq",   64'(sif.memReqOut), 64'd0);
        chk("s3_done_wdata",    sif.memWdataOut, 64'd0);
        chk("s3_done_inready",  64'(sif.inReady), 64'd1);
        chk("s3_done_stall",    64'(sif.stallCountOut), 64'd4);

        // Scenario 4: stray ack in IDLE, stray store in RESULT
        sif.memAckIn = 1; sif.memRdataIn = 64'hDEAD;
        sif.storeValidIn = 1; sif.storeDataIn = 64'h77;
        step();
        sif.memAckIn = 0; sif.memRdataIn = '0;
        sif.storeValidIn = 0; sif.storeDataIn = '0;
        chk("s4_idle_inready", 64'(sif.inReady), 64'd1);
        chk("s4_idle_memreq",  64'(sif.memReqOut), 64'd0);
        chk("s4_idle_src1",    sif.src1DataOut, 64'd0);
        chk("s4_idle_stall",   64'(sif.stallCountOut), 64'd4);
        sif.inValid = 1;
        step();
        sif.inValid = 0;
        sif.storeValidIn = 1; sif.storeDataIn = 64'h99;
        sif.memAckIn = 1; sif.memRdataIn = 64'h123;
        step();
        sif.storeValidIn = 0; sif.storeDataIn = '0;
        sif.memAckIn = 0; sif.memRdataIn = '0;
        chk("s4_res_outvalid",   64'(sif.outValid), 64'd1);
        chk("s4_res_storeready", 64'(sif.storeReadyOut), 64'd0);
        chk("s4_res_src1",       sif.src1DataOut, 64'd0);
        chk("s4_res_src2",       sif.src2DataOut, 64'd0);
        chk("s4_res_memreq",     64'(sif.memReqOut), 64'd0);
        sif.outReady = 1;
        step();
        sif.outReady = 0;
        chk("s4_done_inready",  64'(sif.inReady), 64'd1);
        chk("s4_done_memwdata", sif.memWdataOut, 64'd0);

        // Scenario 5: reset in the middle of the second read
        sif.inValid = 1; sif.isMemSrc1In = 1; sif.isMemSrc2In = 1;
        sif.addrSrc1In = 64'h4000; sif.addrSrc2In = 64'h5000;
        step();
        sif.inValid = 0; sif.isMemSrc1In = 0; sif.isMemSrc2In = 0;
        sif.memAckIn = 1; sif.memRdataIn = 64'hC3;
        step();
        sif.memAckIn = 0; sif.memRdataIn = '0;
        chk("s5_rd2_addr", sif.memAddrOut, 64'h5000);
        chk("s5_rd2_src1", sif.src1DataOut, 64'hC3);
        step();
        chk("s5_rd2_stall", 64'(sif.stallCountOut), 64'd5);
        chk("s5_rd2_req",   64'(sif.memReqOut), 64'd1);
        reset = 1'b1;
        #1;
        chk("s5_rst_memreq",   64'(sif.memReqOut), 64'd0);
        chk("s5_rst_memaddr",  sif.memAddrOut, 64'd0);
        chk("s5_rst_stall",    64'(sif.stallCountOut), 64'd0);
        chk("s5_rst_inready",  64'(sif.inReady), 64'd0);
        chk("s5_rst_src1",     sif.src1DataOut, 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("s5_rel_inready", 64'(sif.inReady), 64'd1);
        step();
        step();
        chk("s5_noretry_memreq", 64'(sif.memReqOut), 64'd0);
        chk("s5_noretry_stall",  64'(sif.stallCountOut), 64'd0);
        chk("s5_noretry_inready", 64'(sif.inReady), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
